fltadd_seq: RTL and testbench
=============================

Name: fltadd_seq

Overview:
- Parametrised, multi-cycle floating-point add/subtract unit. Successor to the no-round, same-sign-only float adder.
- Adds true subtraction (mixed signs or `op_sub`), round-to-nearest-even with guard/round/sticky, overflow saturation and underflow flush.
- Operands and result travel on ports with a `start`/`done` handshake, not through data memory.
- The program-3 testbench and later datapaths use it as the float arithmetic engine.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width; the hidden bit is implied.
- W, 1+EXP_W+MAN_W, derived operand width. Not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- op_sub  in  1  1 computes a-b, 0 computes a+b; captured with start.
- a  in  W  operand A, {sign, exp, mant}; captured with start.
- b  in  W  operand B; captured with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  W  sum/difference; held stable until the next accepted start.
- ovf  out  1  overflow saturated this result; valid with result.
- unf  out  1  underflow flushed this result; valid with result.
- zero  out  1  result is zero; valid with result.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, result=0, ovf=0, unf=0, zero=0. Reset mid-operation aborts the operation; no done is issued.
- Format: value = (-1)^s × 1.mant × 2^(exp-bias). exp==0 means zero and the mantissa is ignored (no subnormals). exp all-ones is an ordinary finite exponent (no inf/NaN).
- Effective B sign = b.sign XOR op_sub. Equal effective signs → magnitude add; otherwise → magnitude subtract of smaller from larger; result sign is the larger magnitude's sign.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND.
- IDLE: on start=1, capture a, b, op_sub and unpack, with hidden bit = (exp!=0). Go to ALIGN; busy=1 next cycle. start while not IDLE is ignored.
- ALIGN: order the operands so the larger exponent is first. Shift the smaller mantissa right one bit per cycle while the remaining diff > 0. Shifted-out bits feed guard, round, sticky (sticky = OR of all lower bits). Diff is capped at MAN_W+3; beyond the cap the operand becomes pure sticky. When diff==0, go to ADD. Occupies d+1 cycles, d = min(|expA-expB|, MAN_W+3).
- ADD: one cycle. MAN_W+4-bit add/subtract including the GRS bits. For equal exponents under subtract, magnitude compare picks the minuend.
- NORM, one shift per cycle:
  - carry-out → right shift 1, exp+1, LSB ORed into sticky;
  - else while MSB==0 and mantissa!=0 → left shift 1, exp-1;
  - otherwise go to ROUND.
  - Occupies n+1 cycles, n = shifts performed.
- ROUND, one cycle:
  - round up when G & (R|S|LSB); a round carry renormalises in the same cycle (exp+1).
  - Then apply overflow, underflow and zero, pack result, pulse done, go to IDLE. busy=0 in the done cycle.
- Latency: done is high on edge d+n+4 after the start edge. Back-to-back: start may be asserted in the done cycle's following IDLE cycle.
- Overflow: final exp > 2^EXP_W-1 → result = {sign, all-ones exp, all-ones mant}, ovf=1.
- Underflow: final exp < 1 → result=0, unf=1, zero=1.
- Zero handling:
  - Exact cancellation, or both operands zero → result=0 (sign 0), zero=1.
  - One operand zero → result is the other operand with its effective sign; no rounding; still passes through the FSM at d=0.
- Flags are cleared on each accepted start and updated together with result.

Test Plan (EXP_W=5, MAN_W=10, bias 15):
- a=0x3C00, b=0x3C00, op_sub=0 → result=0x4000, zero=0, done on edge 5 (d=0, n=1).
- a=0x3C00, b=0x3C00, op_sub=1 → result=0x0000, zero=1, ovf=0, unf=0.
- Tie and rounding: a=0x3C00, b=0x1000 → 0x3C00 (tie to even). a=0x3C00, b=0x1001 → 0x3C01 (round up).
- Normalisation: a=0x3C01, b=0x3C00, op_sub=1 → 0x1400, done on edge 14 (n=10). Mixed signs a=0xC000, b=0x3C00, op_sub=0 → 0xBC00.
- Overflow: a=0x7FFF, b=0x7FFF → result=0x7FFF, ovf=1. Underflow: a=0x0401, b=0x0400, op_sub=1 → result=0, unf=1, zero=1.
- Control: reset=0 while in NORM → all outputs 0 immediately, no done. start pulsed while busy → ignored, first result unchanged. a=0x0000, b=0xBC00 → 0xBC00.

Source files
------------

// File: rtl/fltadd_seq.sv
// fltadd_seq: multi-cycle floating-point add/subtract with round-to-nearest-even,
// overflow saturation and underflow flush, driven by a start/done handshake.
module fltadd_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ovf,
    output logic                   unf,
    output logic                   zero
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int M   = MAN_W + 4;             // hidden + mantissa + guard/round/sticky
    localparam int XW  = EXP_W + 2;             // signed working exponent, room for over/underflow
    localparam int DW  = $clog2(MAN_W + 4);
    localparam int CAP = MAN_W + 3;

    localparam logic signed [XW-1:0] X_ONE   = XW'(1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    state_t                 state_reg;
    logic                   sign_l_reg, sign_s_reg;
    logic signed [XW-1:0]   exp_reg;
    logic [M-1:0]           man_l_reg, man_s_reg;
    logic [DW-1:0]          diff_reg;
    logic [M:0]             sum_reg;

    // Operand unpack and ordering, evaluated on the inputs while IDLE.
    logic [EXP_W-1:0] ea, eb, ediff;
    logic             a_nz, b_nz, sb_eff, a_ge_b;
    logic [M-1:0]     ma, mb;
    logic [DW-1:0]    d_cap;

    assign ea     = a[W-2:MAN_W];
    assign eb     = b[W-2:MAN_W];
    assign a_nz   = (ea != '0);
    assign b_nz   = (eb != '0);
    assign ma     = a_nz ? {1'b1, a[MAN_W-1:0], 3'b000} : '0;
    assign mb     = b_nz ? {1'b1, b[MAN_W-1:0], 3'b000} : '0;
    assign sb_eff = b[W-1] ^ op_sub;
    // Full magnitude compare also settles the minuend for equal exponents.
    assign a_ge_b = {ea, ma} >= {eb, mb};
    assign ediff  = a_ge_b ? (ea - eb) : (eb - ea);

    always_comb begin
        d_cap = '0;
        // A zero operand skips alignment entirely so the other passes through unchanged.
        if (a_nz && b_nz)
            d_cap = (32'(ediff) > CAP) ? DW'(CAP) : DW'(ediff);
    end

    // Rounding and final exponent, consumed in ROUND.
    logic                   rnd_up;
    logic [MAN_W+1:0]       rnd;
    logic signed [XW-1:0]   exp_f;
    logic [MAN_W-1:0]       man_f;

    assign rnd_up = sum_reg[2] & (sum_reg[1] | sum_reg[0] | sum_reg[3]);
    assign rnd    = {1'b0, sum_reg[M-1:3]} + (MAN_W+2)'(rnd_up);
    assign exp_f  = exp_reg + XW'(rnd[MAN_W+1]);
    assign man_f  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            zero       <= 1'b0;
            sign_l_reg <= 1'b0;
            sign_s_reg <= 1'b0;
            exp_reg    <= '0;
            man_l_reg  <= '0;
            man_s_reg  <= '0;
            diff_reg   <= '0;
            sum_reg    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        ovf        <= 1'b0;
                        unf        <= 1'b0;
                        zero       <= 1'b0;
                        sign_l_reg <= a_ge_b ? a[W-1] : sb_eff;
                        sign_s_reg <= a_ge_b ? sb_eff : a[W-1];
                        exp_reg    <= XW'(a_ge_b ? ea : eb);
                        man_l_reg  <= a_ge_b ? ma : mb;
                        man_s_reg  <= a_ge_b ? mb : ma;
                        diff_reg   <= d_cap;
                        state_reg  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (diff_reg != '0) begin
                        man_s_reg <= {1'b0, man_s_reg[M-1:2], man_s_reg[1] | man_s_reg[0]};
                        diff_reg  <= diff_reg - DW'(1);
                    end else begin
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    if (sign_l_reg == sign_s_reg)
                        sum_reg <= {1'b0, man_l_reg} + {1'b0, man_s_reg};
                    else
                        sum_reg <= {1'b0, man_l_reg} - {1'b0, man_s_reg};
                    state_reg <= NORM;
                end
                NORM: begin
                    if (sum_reg[M]) begin
                        sum_reg <= {1'b0, sum_reg[M:2], sum_reg[1] | sum_reg[0]};
                        exp_reg <= exp_reg + X_ONE;
                    end else if (!sum_reg[M-1] && sum_reg != '0) begin
                        sum_reg <= {sum_reg[M-1:0], 1'b0};
                        exp_reg <= exp_reg - X_ONE;
                    end else begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    if (sum_reg == '0) begin
                        result <= '0;
                        zero   <= 1'b1;
                    end else if (exp_f > EXP_MAX) begin
                        result <= {sign_l_reg, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                        ovf    <= 1'b1;
                    end else if (exp_f < X_ONE) begin
                        result <= '0;
                        unf    <= 1'b1;
                        zero   <= 1'b1;
                    end else begin
                        result <= {sign_l_reg, exp_f[EXP_W-1:0], man_f};
                    end
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fltadd_seq.sv
// Directed bench for fltadd_seq (EXP_W=5, MAN_W=10, bias 15) with hand-computed results.
module tb_fltadd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, ovf, unf, zero;
    logic [15:0] result;

    int tests = 0;
    int fails = 0;
    int edges;
    int done_seen;

    fltadd_seq #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .ovf(ovf), .unf(unf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one start pulse; returns #1 after the accepting edge (edge 0).
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic sub);
        @(negedge clk);
        a = ta; b = tb_v; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(inout int e);
        while (!done && e < 60) begin
            @(posedge clk); #1;
            e++;
        end
        check("timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic sub, input logic [15:0] exp_res,
                          input logic [2:0] exp_flags, input int exp_edges);
        int e;
        issue(ta, tb_v, sub);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        e = 0;
        wait_done(e);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_flags"}, 32'({ovf, unf, zero}), 32'(exp_flags));
        check({tag, "_latency"}, 32'(e), 32'(exp_edges));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        $display("[TB] %s a=%h b=%h sub=%0d -> result=%h ovf=%0d unf=%0d zero=%0d done@edge %0d",
                 tag, ta, tb_v, sub, result, ovf, unf, zero, e);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("reset_outputs", 32'({busy, done, ovf, unf, zero, result}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // name, a, b, op_sub, result, {ovf,unf,zero}, done edge
        run_op("one_plus_one",  16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 5);
        run_op("one_minus_one", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b001, 4);
        run_op("tie_even",      16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000, 15);
        run_op("round_up",      16'h3C00, 16'h1001, 1'b0, 16'h3C01, 3'b000, 15);
        run_op("norm_left",     16'h3C01, 16'h3C00, 1'b1, 16'h1400, 3'b000, 14);
        run_op("mixed_sign",    16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000, 6);
        run_op("overflow",      16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 3'b100, 5);

        // Reset asserted while the unit is normalising.
        issue(16'h3C01, 16'h3C00, 1'b1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_mid_norm", 32'({busy, done, ovf, unf, zero, result}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("reset_no_done", 32'(done_seen), 32'd0);
        $display("[TB] reset_mid_norm result=%h busy=%0d activity_after_reset=%0d", result, busy, done_seen);

        run_op("underflow",     16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b011, 14);
        run_op("zero_operand",  16'h0000, 16'hBC00, 1'b0, 16'hBC00, 3'b000, 4);

        // A second start while busy must be ignored.
        issue(16'h3C00, 16'h3C00, 1'b0);
        edges = 0;
        @(negedge clk);
        a = 16'h7FFF; b = 16'h7FFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        wait_done(edges);
        check("busy_start_result", 32'(result), 32'h4000);
        check("busy_start_flags", 32'({ovf, unf, zero}), 32'd0);
        check("busy_start_latency", 32'(edges), 32'd5);
        $display("[TB] busy_start result=%h ovf=%0d done@edge %0d", result, ovf, edges);
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("busy_start_no_second", 32'(done_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
